// File: rtl/prog_counter.sv
// Programmable up/down counter with a small IDLE/RUN/DONE controller.
// A start request latches limit, dir and mode. The counter then steps between
// 0 and the latched limit. In wrap mode it restarts at the far end and pulses
// wrap. In one-shot mode it parks at the terminal value and enters DONE.
module prog_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] limit_q;
  logic             dir_q;
  logic             mode_q;
  logic [WIDTH-1:0] term_val;

  // Terminal value is limit_q when counting up and 0 when counting down.
  assign term_val = dir_q ? '0 : limit_q;

  // tc depends only on registered state and count, so it is stable within a cycle.
  assign tc = (state == RUN) && (count == term_val);

  // Controller, counter and registered status outputs. The priority order is
  // rst > stop > start > clr > load > count step.
  // NOTE: asynchronous reset appears in the sensitivity list. All state uses
  // non-blocking assignments, so every register samples values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      limit_q <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      wrap    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // wrap is a single-cycle pulse. It is low unless a wrap event occurs this cycle.
      wrap <= 1'b0;
      if (stop) begin
        // An abort holds count. In IDLE it also blocks a simultaneous start.
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (start) begin
        limit_q <= limit;
        dir_q   <= dir;
        mode_q  <= mode;
        count   <= dir ? limit : '0;
        state   <= RUN;
        busy    <= 1'b1;
        done    <= 1'b0;
      end else if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= load_val;
      end else if (state == RUN && en) begin
        if (tc) begin
          if (mode_q) begin
            // One-shot: count stays at the terminal value and the block parks in DONE.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            count <= dir_q ? limit_q : '0;
            wrap  <= 1'b1;
          end
        end else begin
          // The step is modulo 2^WIDTH, so a loaded value above limit_q
          // wraps through 0 and still reaches the terminal value.
          count <= dir_q ? count - ONE : count + ONE;
        end
      end
    end
  end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter, limit and load-value width in bits; legal range 2..32.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request; latches limit, dir and mode and begins counting.
REQ-005 stop  input  1  abort request; returns the block to IDLE.
REQ-006 en  input  1  count enable; count advances only in RUN when en=1.
REQ-007 clr  input  1  synchronous clear of the count value.
REQ-008 load  input  1  synchronous load of load_val into the count value.
REQ-009 load_val  input  WIDTH  value written by load.
REQ-010 limit  input  WIDTH  terminal value for the count; range is 0..limit.
REQ-011 dir  input  1  0 = count up, 1 = count down.
REQ-012 mode  input  1  0 = wrap (free-running), 1 = one-shot.
REQ-013 count  output  WIDTH  current count value, registered.
REQ-014 tc  output  1  combinational; high when count equals the terminal value (limit_q if up, 0 if down) and state is RUN.
REQ-015 wrap  output  1  registered one-cycle pulse; high the cycle after each wrap event.
REQ-016 busy  output  1  high in RUN.
REQ-017 done  output  1  high in DONE.

Function
REQ-018 The FSM SHALL have three states, IDLE, RUN and DONE, with transitions as in REQ-019 to REQ-021.
- IDLE + start -> RUN.
- RUN + stop -> IDLE.
- RUN + one-shot terminal event -> DONE.
- DONE + start -> RUN.
- DONE + stop -> IDLE.
REQ-019 On the start edge the block SHALL latch limit, dir and mode into limit_q, dir_q and mode_q, and load count with 0 (up) or limit (down); these latched values SHALL remain constant until the next start.
REQ-020 stop SHALL take priority over start in the same cycle; count holds its value on stop.
REQ-021 A terminal event SHALL be a cycle in RUN with en=1 and tc=1.
REQ-022 In RUN with en=1 and no terminal event, count SHALL increment by 1 (up) or decrement by 1 (down).
REQ-023 On a terminal event in wrap mode, count SHALL wrap to 0 (up) or limit_q (down), wrap SHALL pulse the next cycle, and the state SHALL stay RUN.
REQ-024 On a terminal event in one-shot mode, count SHALL hold at its terminal value, the state SHALL go to DONE, and wrap SHALL not pulse.
REQ-025 Priority within RUN SHALL be clr > load > count step.
- clr sets count to 0.
- load sets count to load_val.
- Neither clr nor load generates wrap or a terminal event in that cycle.
REQ-026 clr and load in IDLE or DONE SHALL still update count; en is ignored outside RUN.
REQ-027 start arriving in the same cycle as clr or load SHALL win over both: count takes its start value.
REQ-028 A load_val above limit_q in up mode SHALL be accepted; count then increments, wraps modulo 2^WIDTH through 0, and reaches limit_q naturally.
REQ-029 With limit_q=0, count SHALL stay at 0 and every enabled RUN cycle SHALL be a terminal event (wrap pulses every cycle in wrap mode).
REQ-030 Arithmetic SHALL be WIDTH-bit unsigned with no carry output; a full-scale limit (2^WIDTH-1) SHALL be supported.

Reset
REQ-031 Asserting rst SHALL immediately force the following, regardless of clk:
- state = IDLE
- count = 0
- limit_q = 0, dir_q = 0, mode_q = 0
- wrap = 0, busy = 0, done = 0
REQ-032 rst asserted mid-count SHALL abort the count with no wrap or done pulse; after release the block waits for start.
REQ-033 Deassertion of rst SHALL be synchronised to clk by the integrating design; the block adds no reset synchroniser.

Verification
REQ-034 WIDTH=8, limit=255, up, wrap, en held high for 512 cycles -> count 0..255 twice; tc high on each 255; wrap pulses twice, each one cycle after count=255.
REQ-035 limit=9, down, one-shot, en=1 -> count 9..0; done rises the cycle after count=0 at tc; count holds 0; no wrap pulse; busy falls with done.
REQ-036 In RUN, up, limit=20, assert clr and load (load_val=7) together at count=12 -> count=0 next cycle; then load alone -> 7; en=0 during load leaves count at 7.
REQ-037 limit=0, wrap mode, en=1 for 5 cycles -> count stays 0; tc high continuously; wrap pulses 5 consecutive cycles.
REQ-038 Assert rst asynchronously at count=100 between clock edges -> count=0, busy=0 immediately; start after release restarts from 0.
REQ-039 start and stop asserted together in IDLE -> state stays IDLE; start alone in DONE -> RUN with new limit latched and count reset to its start value.
